// File: rtl/fx2_sched.sv
// Endpoint scheduler for the FX2 synchronous slave-FIFO bus: arbitrates EP2 command
// reads, EP8 status writes (closed with PKTEND) and EP6 sample bursts onto one FD bus.
module fx2_sched #(
  parameter int unsigned BURST_LEN = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] fd_i,
  output logic [15:0] fd_o,
  output logic        fd_oe,
  output logic [1:0]  addr,
  output logic        slrd_n,
  output logic        slwr_n,
  output logic        sloe_n,
  output logic        pktend_n,
  input  logic        ep2_ne,
  input  logic        ep6_nf,
  input  logic        ep8_nf,
  input  logic [15:0] smp_data,
  input  logic        smp_valid,
  output logic        smp_ready,
  input  logic [15:0] stat_word,
  input  logic        stat_req,
  output logic        stat_ack,
  output logic [15:0] cmd_data,
  output logic        cmd_valid
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEL    = 3'd1,
    RD     = 3'd2,
    RD_REL = 3'd3,
    WSTAT  = 3'd4,
    PKTEND = 3'd5,
    WSMP   = 3'd6,
    WEND   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    G_RD   = 2'd0,
    G_STAT = 2'd1,
    G_SMP  = 2'd2
  } grant_t;

  localparam logic [1:0]  ADDR_EP2  = 2'b00;
  localparam logic [1:0]  ADDR_EP6  = 2'b10;
  localparam logic [1:0]  ADDR_EP8  = 2'b11;
  localparam logic [15:0] BURST_MAX = 16'(BURST_LEN);

  state_t      state_r;
  grant_t      grant_r;
  logic [15:0] count_r;
  logic        smp_ready_s;
  logic        smp_take_s;

  // Sample handshake: only in WSMP, with FIFO space and burst budget left
  always_comb begin
    smp_ready_s = 1'b0;
    if ((state_r == WSMP) && ep6_nf && (count_r < BURST_MAX)) begin
      smp_ready_s = 1'b1;
    end else begin
      smp_ready_s = 1'b0;
    end
    smp_take_s = smp_ready_s & smp_valid;
  end

  assign smp_ready = smp_ready_s;

  // Arbitration FSM; every bus pin is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      grant_r   <= G_SMP;
      count_r   <= 16'd0;
      fd_o      <= 16'd0;
      fd_oe     <= 1'b0;
      addr      <= ADDR_EP6;
      slrd_n    <= 1'b1;
      slwr_n    <= 1'b1;
      sloe_n    <= 1'b1;
      pktend_n  <= 1'b1;
      cmd_data  <= 16'd0;
      cmd_valid <= 1'b0;
      stat_ack  <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      stat_ack  <= 1'b0;
      case (state_r)
        IDLE: begin
          slrd_n   <= 1'b1;
          slwr_n   <= 1'b1;
          sloe_n   <= 1'b1;
          pktend_n <= 1'b1;
          fd_oe    <= 1'b0;
          // Fixed priority: host commands, then status, then the sample stream
          if (en && ep2_ne) begin
            addr    <= ADDR_EP2;
            grant_r <= G_RD;
            state_r <= SEL;
          end else if (en && stat_req && ep8_nf) begin
            addr    <= ADDR_EP8;
            grant_r <= G_STAT;
            state_r <= SEL;
          end else if (en && smp_valid && ep6_nf) begin
            addr    <= ADDR_EP6;
            grant_r <= G_SMP;
            state_r <= SEL;
          end else begin
            state_r <= IDLE;
          end
        end
        SEL: begin
          case (grant_r)
            G_RD: begin
              sloe_n  <= 1'b0;
              slrd_n  <= 1'b0;
              state_r <= RD;
            end
            G_STAT: begin
              fd_oe    <= 1'b1;
              fd_o     <= stat_word;
              slwr_n   <= 1'b0;
              stat_ack <= 1'b1;
              state_r  <= WSTAT;
            end
            G_SMP: begin
              fd_oe   <= 1'b1;
              count_r <= 16'd0;
              state_r <= WSMP;
            end
            default: begin
              state_r <= IDLE;
            end
          endcase
        end
        RD: begin
          cmd_data  <= fd_i;
          cmd_valid <= 1'b1;
          slrd_n    <= 1'b1;
          sloe_n    <= 1'b1;
          state_r   <= RD_REL;
        end
        RD_REL: begin
          state_r <= IDLE;
        end
        WSTAT: begin
          slwr_n   <= 1'b1;
          pktend_n <= 1'b0;
          state_r  <= PKTEND;
        end
        PKTEND: begin
          pktend_n <= 1'b1;
          fd_oe    <= 1'b0;
          state_r  <= WEND;
        end
        WSMP: begin
          // Any cycle without a handshake ends the burst: empty, full or budget spent
          if (smp_take_s) begin
            fd_o    <= smp_data;
            slwr_n  <= 1'b0;
            count_r <= count_r + 16'd1;
            state_r <= WSMP;
          end else begin
            slwr_n  <= 1'b1;
            fd_oe   <= 1'b0;
            state_r <= WEND;
          end
        end
        WEND: begin
          slwr_n  <= 1'b1;
          fd_oe   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          slrd_n   <= 1'b1;
          slwr_n   <= 1'b1;
          sloe_n   <= 1'b1;
          pktend_n <= 1'b1;
          fd_oe    <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule
